// File: rtl/design_params_pkg.sv
// Shared constants and types for the timer bus environment.
//   - bus address/data widths and the timer_periph register map
//   - FSM state encoding for timer_bus_master
//   - bit positions inside rsp_err
package design_params_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;

  // timer_periph register map
  localparam logic [ADDR_WIDTH-1:0] P_ADDR_CONTROL = 8'h00;
  localparam logic [ADDR_WIDTH-1:0] P_ADDR_LOAD    = 8'h08;
  localparam logic [ADDR_WIDTH-1:0] P_ADDR_STATUS  = 8'h10;

  // rsp_err bit indices
  localparam int P_ERR_GNT_TO   = 0;  // grant never arrived
  localparam int P_ERR_SLOW_GNT = 1;  // grant later than allowed
  localparam int P_ERR_SLOW_REL = 2;  // gnt fell late or not at all

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE,
    ST_RESP
  } bus_state_t;

endpackage

// File: rtl/bus_lat_counter.sv
// Saturating latency counter with synchronous clear and count enable.
//   clk, reset : clock, async active-high reset
//   clr        : zero the count (wins over en)
//   en         : count this edge (holds at all-ones)
//   count      : current count
//   at_last    : count >= THRESH-1, i.e. one more enabled edge reaches THRESH
module bus_lat_counter #(
  parameter int WIDTH  = 4,
  parameter int THRESH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_last
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count + 1'b1;
    end
  end

  assign at_last = (count >= WIDTH'(THRESH - 1));

endmodule

// File: rtl/timer_bus_master.sv
// Initiator for the req/gnt handshake bus served by timer_periph.
// One bus transaction per accepted command; reports read data, measured
// grant/release latencies and protocol-violation flags.
//   clk, reset                         : clock, async active-high reset
//   cmd_valid/cmd_ready                : command handshake
//   cmd_write, cmd_addr, cmd_wdata     : command payload
//   rsp_valid/rsp_ready                : response handshake (held until taken)
//   rsp_rdata, rsp_err, rsp_gnt_lat,
//   rsp_rel_lat                        : response payload
//   busy                               : transaction in progress
//   req, addr, wdata, write_en         : bus outputs
//   gnt, rdata                         : bus inputs
module timer_bus_master #(
  parameter int P_ADDR_WIDTH  = design_params_pkg::ADDR_WIDTH,
  parameter int P_DATA_WIDTH  = design_params_pkg::DATA_WIDTH,
  parameter int P_GNT_MAX     = 3,
  parameter int P_REL_MAX     = 1,
  parameter int P_GNT_TIMEOUT = 8,
  parameter int P_REL_TIMEOUT = 4,
  parameter int P_RDATA_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [P_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [P_DATA_WIDTH-1:0] cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [P_DATA_WIDTH-1:0] rsp_rdata,
  output logic [2:0]              rsp_err,
  output logic [3:0]              rsp_gnt_lat,
  output logic [2:0]              rsp_rel_lat,
  output logic                    busy,
  output logic                    req,
  input  logic                    gnt,
  output logic [P_ADDR_WIDTH-1:0] addr,
  output logic [P_DATA_WIDTH-1:0] wdata,
  output logic                    write_en,
  input  logic [P_DATA_WIDTH-1:0] rdata
);

  import design_params_pkg::*;

  bus_state_t state;
  logic       accept;
  logic [3:0] gnt_cnt;
  logic       gnt_last;
  logic [2:0] rel_cnt;
  logic       rel_last;
  logic [3:0] gnt_lat_now;
  logic       rd_pend;      // read capture still outstanding
  logic [1:0] rd_cnt;       // edges since the handshake edge
  logic       capture_now;
  logic       rd_done;

  // A stale gnt from the previous slave must fall before a new req may rise.
  assign cmd_ready = (state == ST_IDLE) && !gnt;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);

  bus_lat_counter #(.WIDTH(4), .THRESH(P_GNT_TIMEOUT)) u_gnt_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      ((state == ST_GRANT) && !gnt),
    .count   (gnt_cnt),
    .at_last (gnt_last)
  );

  bus_lat_counter #(.WIDTH(3), .THRESH(P_REL_TIMEOUT)) u_rel_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      ((state == ST_RELEASE) && gnt),
    .count   (rel_cnt),
    .at_last (rel_last)
  );

  // Latency includes the granting edge itself; saturate at 15.
  assign gnt_lat_now = (&gnt_cnt) ? gnt_cnt : gnt_cnt + 4'd1;

  // Capture may coincide with the exit edge, so "done" includes this edge.
  assign capture_now = rd_pend && (rd_cnt == 2'(P_RDATA_LAT));
  assign rd_done     = !rd_pend || capture_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      req         <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      write_en    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= '0;
      rsp_gnt_lat <= '0;
      rsp_rel_lat <= '0;
      rd_pend     <= 1'b0;
      rd_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr        <= cmd_addr;
            write_en    <= cmd_write;
            wdata       <= cmd_write ? cmd_wdata : '0;
            req         <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= '0;
            rsp_gnt_lat <= '0;
            rsp_rel_lat <= '0;
            rd_pend     <= 1'b0;
            rd_cnt      <= '0;
            state       <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (gnt) begin
            // Handshake edge.
            req                     <= 1'b0;
            rsp_gnt_lat             <= gnt_lat_now;
            rsp_err[P_ERR_SLOW_GNT] <= (gnt_lat_now > 4'(P_GNT_MAX));
            if (!write_en) begin
              if (P_RDATA_LAT == 0) begin
                rsp_rdata <= rdata;
              end else begin
                rd_pend <= 1'b1;
                rd_cnt  <= 2'd1;
              end
            end
            state <= ST_RELEASE;
          end else if (gnt_last) begin
            // Abort: no read capture is armed.
            req                   <= 1'b0;
            rsp_gnt_lat           <= 4'(P_GNT_TIMEOUT);
            rsp_err[P_ERR_GNT_TO] <= 1'b1;
            state                 <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (capture_now) begin
            rsp_rdata <= rdata;
            rd_pend   <= 1'b0;
          end else if (rd_pend) begin
            rd_cnt <= rd_cnt + 2'd1;
          end

          if (gnt && rel_last) begin
            // gnt stuck high: give up waiting; cmd_ready still blocks on gnt.
            rsp_rel_lat             <= 3'(P_REL_TIMEOUT);
            rsp_err[P_ERR_SLOW_REL] <= 1'b1;
            rsp_valid               <= 1'b1;
            state                   <= ST_RESP;
          end else if (!gnt && rd_done) begin
            rsp_rel_lat             <= rel_cnt;
            rsp_err[P_ERR_SLOW_REL] <= (rel_cnt > 3'(P_REL_MAX));
            rsp_valid               <= 1'b1;
            state                   <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_bus_master.sv
// Self-checking bench for timer_bus_master. The bus slave is scripted per
// transaction (grant delay, gnt hold after handshake, memory-backed read
// data valid only on the expected capture edge); expected results come
// from the protocol rules applied to that script.
module tb_timer_bus_master;
  import design_params_pkg::*;

  localparam int AW        = ADDR_WIDTH;
  localparam int DW        = DATA_WIDTH;
  localparam int GNT_MAX   = 3;
  localparam int REL_MAX   = 1;
  localparam int GNT_TO    = 8;
  localparam int REL_TO    = 4;
  localparam int RDATA_LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [2:0]    rsp_err;
  logic [3:0]    rsp_gnt_lat;
  logic [2:0]    rsp_rel_lat;
  logic          busy, req, gnt, write_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] mem [256];

  timer_bus_master #(
    .P_ADDR_WIDTH (AW),
    .P_DATA_WIDTH (DW),
    .P_GNT_MAX    (GNT_MAX),
    .P_REL_MAX    (REL_MAX),
    .P_GNT_TIMEOUT(GNT_TO),
    .P_REL_TIMEOUT(REL_TO),
    .P_RDATA_LAT  (RDATA_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_gnt_lat(rsp_gnt_lat),
    .rsp_rel_lat(rsp_rel_lat),
    .busy       (busy),
    .req        (req),
    .gnt        (gnt),
    .addr       (addr),
    .wdata      (wdata),
    .write_en   (write_en),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus noise guaranteed to differ from the real data word.
  function automatic logic [DW-1:0] junk(input logic [DW-1:0] v);
    return v ^ (16'($urandom) | 16'h0001);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // g   : edge after acceptance on which gnt is first sampled high (> GNT_TO: never)
  // h   : number of edges after the handshake on which gnt stays high
  // hold: cycles rsp_ready is held low while the response is pending
  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int g, input int h, input int hold);
    bit            to, capture, seen;
    int            hh, exp_glat, exp_rlat, exp_exit, j;
    logic [2:0]    exp_err;
    logic [DW-1:0] rd_val, exp_rdata;

    to        = (g > GNT_TO);
    hh        = to ? 0 : h;
    capture   = !wr && !to;
    rd_val    = mem[a];
    exp_glat  = to ? GNT_TO : g;
    exp_rlat  = (hh >= REL_TO) ? REL_TO : hh;
    exp_err   = 3'b000;
    exp_err[P_ERR_GNT_TO]   = to;
    exp_err[P_ERR_SLOW_GNT] = !to && (g > GNT_MAX);
    exp_err[P_ERR_SLOW_REL] = (hh > REL_MAX);
    exp_exit  = (hh >= REL_TO) ? REL_TO : imax(hh + 1, capture ? RDATA_LAT : 0);
    exp_rdata = capture ? rd_val : '0;

    // Command acceptance
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    rsp_ready = 1'b0; gnt = 1'b0; rdata = junk(rd_val);
    #1 check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 16'($urandom);
    check("req_rise", 32'(req), 32'd1);
    check("busy", 32'(busy), 32'd1);
    check("bus_addr", 32'(addr), 32'(a));
    check("bus_we", 32'(write_en), 32'(wr));
    check("bus_wdata", 32'(wdata), wr ? 32'(wd) : 32'd0);

    // Grant wait
    for (int k = 1; k <= (to ? GNT_TO : g); k++) begin
      check("req_held", 32'(req), 32'd1);
      gnt   = (k == g);
      rdata = (capture && RDATA_LAT == 0 && k == g) ? rd_val : junk(rd_val);
      tick();
    end
    check("req_drop", 32'(req), 32'd0);

    // Release wait
    seen = 1'b0;
    j    = 1;
    while (j <= 12 && !seen) begin
      gnt   = (j <= hh);
      rdata = (capture && j == RDATA_LAT) ? rd_val : junk(rd_val);
      tick();
      if (rsp_valid) begin
        seen = 1'b1;
        check("rsp_exit_edge", 32'(j), 32'(exp_exit));
      end
      j++;
    end
    check("rsp_arrived", 32'(seen), 32'd1);

    // Response held; a competing command must not be taken
    for (int c = 0; c <= hold; c++) begin
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_gnt_lat", 32'(rsp_gnt_lat), 32'(exp_glat));
      check("rsp_rel_lat", 32'(rsp_rel_lat), 32'(exp_rlat));
      check("bus_addr_hold", 32'(addr), 32'(a));
      check("req_idle_resp", 32'(req), 32'd0);
      if (c == hold) break;
      cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 8'($urandom);
      gnt = (j <= hh); j++;
      #1 check("cmd_ready_resp", 32'(cmd_ready), 32'd0);
      tick();
    end

    // Consume
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    gnt = (j <= hh); j++;
    tick();
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("busy_clear", 32'(busy), 32'd0);

    // A lingering gnt keeps the port closed until it falls
    while (j <= hh) begin
      gnt = 1'b1;
      #1 check("cmd_ready_gnt_hi", 32'(cmd_ready), 32'd0);
      check("req_gnt_hi", 32'(req), 32'd0);
      tick();
      j++;
    end
    gnt = 1'b0;
    #1 check("cmd_ready_reopen", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    if (wr && !to) mem[a] = wd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[P_ADDR_LOAD] = 16'h1234;

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; gnt = 1'b0; rdata = '0;
    #12;
    check("rst_req", 32'(req), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_fields", {rsp_rdata, 5'b0, rsp_err, rsp_gnt_lat, rsp_rel_lat, 1'b0}, 32'd0);
    check("rst_bus", {addr, wdata, 7'b0, write_en}, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    gnt = 1'b1;
    #1 check("rst_cmd_ready_gnt", 32'(cmd_ready), 32'd0);
    gnt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Ideal slave read
    run_txn(1'b0, P_ADDR_LOAD, 16'h0, 2, 1, 0);
    // Slow-grant write, then read back
    run_txn(1'b1, P_ADDR_LOAD, 16'hABCD, 4, 1, 0);
    run_txn(1'b0, P_ADDR_LOAD, 16'h0, 2, 1, 0);
    // Grant never arrives
    run_txn(1'b0, P_ADDR_STATUS, 16'h0, 99, 0, 0);
    // Slow release
    run_txn(1'b0, P_ADDR_CONTROL, 16'h0, 1, 2, 0);
    // gnt stuck high past the release timeout
    run_txn(1'b1, P_ADDR_CONTROL, 16'h5A5A, 2, 7, 1);
    // Back-to-back with slow consumer
    run_txn(1'b1, 8'h20, 16'h1111, 2, 1, 5);
    run_txn(1'b0, 8'h20, 16'h0, 3, 0, 5);

    // Reset while waiting for grant
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30;
    tick();
    cmd_valid = 1'b0;
    check("mid_req_up", 32'(req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(req), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_txn(1'b0, P_ADDR_LOAD, 16'h0, 2, 1, 0);

    // Random traffic
    for (int t = 0; t < 16; t++) begin
      run_txn(1'($urandom), 8'($urandom_range(0, 63)), 16'($urandom),
              int'($urandom_range(1, 10)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_bus_master.md
Name: timer_bus_master

Overview:
- Initiator end of the req/gnt handshake bus that timer_periph responds to.
- Accepts single read/write commands on a valid/ready command port and drives one bus transaction per command: req, addr, wdata, write_en out; gnt, rdata in.
- Returns read data, grant and release latencies, and protocol-violation flags on a response port.
- Used as the SoC-side bus driver and as a reusable protocol checker in the timer environment.

Parameters:
- P_ADDR_WIDTH, design_params_pkg value, bus address width.
- P_DATA_WIDTH, design_params_pkg value, bus data width.
- P_GNT_MAX, 3, maximum legal grant latency in cycles.
- P_REL_MAX, 1, maximum legal gnt-fall latency in cycles after req falls.
- P_GNT_TIMEOUT, 8, grant-wait abort threshold in cycles; must exceed P_GNT_MAX.
- P_REL_TIMEOUT, 4, release-wait abort threshold in cycles.
- P_RDATA_LAT, 1, cycles from handshake edge to the edge where rdata is sampled; range 0..3.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  P_ADDR_WIDTH  target address.
- cmd_wdata  in  P_DATA_WIDTH  write data.
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  P_DATA_WIDTH  read data; 0 for writes and for aborted reads.
- rsp_err  out  3  [0] grant timeout, [1] slow grant, [2] slow or missing release.
- rsp_gnt_lat  out  4  measured grant latency; saturates at 15.
- rsp_rel_lat  out  3  measured release latency; saturates at 7.
- busy  out  1  state != IDLE.
- req  out  1  bus request.
- gnt  in  1  bus grant.
- addr  out  P_ADDR_WIDTH  bus address.
- wdata  out  P_DATA_WIDTH  bus write data.
- write_en  out  1  bus write strobe.
- rdata  in  P_DATA_WIDTH  bus read data.

Behaviour:
- Reset (async, active-high) sets:
  - all outputs to 0, except cmd_ready, which then follows its IDLE equation;
  - state IDLE and all counters to 0.
  - Reset mid-transaction drops req immediately; no response is produced for the in-flight command.
- cmd_ready = (state == IDLE) && !gnt. A new req is never raised while gnt is still high.
- addr, wdata and write_en are registered from the accepted command and held constant from acceptance until the response is consumed. wdata is driven 0 for reads.
- FSM states: IDLE, GRANT, RELEASE, RESP.
- IDLE:
  - On accept: latch the command, set req = 1 on the same edge, clear counters, go to GRANT.
- GRANT (req = 1):
  - Each cycle with gnt = 0, gnt_cnt increments.
  - gnt sampled 1 ends the wait:
    - rsp_gnt_lat = gnt_cnt + 1, so gnt seen on the first edge after req rose gives 1.
    - err[1] is set if rsp_gnt_lat > P_GNT_MAX.
    - That edge is the handshake edge: req drops on it and the state goes to RELEASE.
  - Timeout: gnt_cnt reaching P_GNT_TIMEOUT with gnt = 0 sets err[0] and rsp_gnt_lat = P_GNT_TIMEOUT, drops req, and goes to RELEASE. No read capture follows a timeout.
- RELEASE (req = 0):
  - rel_cnt increments every edge while gnt = 1.
  - Reads: rdata is captured into rsp_rdata P_RDATA_LAT edges after the handshake edge. P_RDATA_LAT = 0 captures on the handshake edge itself.
  - Exit to RESP needs both gnt sampled 0 and, for a non-aborted read, the capture done.
    - rsp_rel_lat = rel_cnt.
    - err[2] is set if rel_cnt > P_REL_MAX.
  - rel_cnt reaching P_REL_TIMEOUT sets err[2] and forces RESP. cmd_ready stays low until gnt falls.
- RESP:
  - rsp_valid = 1 with all rsp_* fields stable.
  - On rsp_ready, rsp_valid drops on the next edge and the state goes to IDLE.
  - A new command can be accepted at the earliest one cycle after rsp_valid falls.
- gnt rising while in IDLE or RESP is ignored for data purposes; it blocks cmd_ready only.
- Counters saturate and never wrap.

Decomposition:
- design_params_pkg gets:
  - the FSM state enum typedef;
  - rsp_err bit-index constants P_ERR_GNT_TO, P_ERR_SLOW_GNT, P_ERR_SLOW_REL.
- P_ADDR_CONTROL/P_ADDR_LOAD/P_ADDR_STATUS and the width parameters are reused from design_params_pkg.
- One natural sub-module: bus_lat_counter, a saturating counter with clear, enable and a threshold compare. It is instantiated for gnt_cnt and rel_cnt.

Test Plan:
- Ideal slave (gnt 2 cycles after req, falls 1 cycle after req, rdata lat 1): read P_ADDR_LOAD holding 0x1234 -> rsp_rdata = 0x1234, gnt_lat = 2, rel_lat = 1, err = 000.
- Write P_ADDR_LOAD 0xABCD to timer_periph at an addr with addr[2:0] == 0 (4-cycle grant) -> gnt_lat = 4, err[1] = 1; then read it back (rdata lat 2 at P_RDATA_LAT = 2) -> 0xABCD.
- Slave never grants -> req drops after 8 cycles, err = 001, rsp_rdata = 0, gnt_lat = 8.
- Slave holds gnt 2 cycles after req falls -> rel_lat = 2, err[2] = 1; gnt stuck high -> RESP forced after 4 cycles, cmd_ready stays 0 until gnt falls.
- Back-to-back commands with rsp_ready held low 5 cycles -> rsp fields stable throughout, second req rises only after response consumed.
- Assert reset while in GRANT -> req = 0 and cmd_ready = 1 immediately when gnt = 0, no rsp_valid; next command completes normally.
